writeback: RTL and testbench

Register-writeback stage of the AsyncARM pipeline. It accepts one completed instruction result from execute through the two-phase trigger/ready handshake used across the pipeline. It then performs up to three sequential writes into the register bank write port (`triggerInw`/`addrw`/`dataIn`). It is the writing end of the register-bank interface whose reading end is decode, and it flags PC writes so fetch can redirect.

---
 rtl/writeback.sv | 208 ++++++++++++++++++++
 tb/tb_writeback.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback.sv
// ---------------------------------------------------------------------------
// writeback
//
// Register-writeback stage of the AsyncARM pipeline. One completed result is
// accepted from execute over a two-phase trigger/ready handshake. It is then
// written into the register bank as up to three sequential requests:
//   W1 : {addrIn1, dataIn1}
//   W2 : {addrIn2, dataIn2}
//   WC : {16, {flagsIn, zeros}}   (CPSR flag update)
// Each request is a two-phase handshake of its own: triggerOutRB toggles
// once, and the request is complete when readyInRB catches up with it.
// pcWrite pulses for one cycle whenever a write to r15 completes, so fetch
// can redirect.
//
// Parameters:
//   DW : data width of results and register-bank data
//   AW : register-bank address width (only [4:0] are significant)
//
// Ports:
//   clk          : clock, all state changes on the rising edge
//   reset        : synchronous, active-low reset
//   dataIn1/2    : primary / secondary result values
//   addrIn1/2    : register indices for write 1 / write 2
//   flagsIn      : NZCV for the CPSR update
//   typeIn       : [0] write1 en, [1] write2 en, [2] CPSR en, [3] reserved
//   triggerIn    : upstream request phase
//   readyOut     : high when idle and nothing is pending at the input
//   dataOutRB    : register-bank write data
//   addrOutRB    : register-bank write address (16 = CPSR)
//   triggerOutRB : register-bank request phase
//   readyInRB    : register-bank acknowledge phase
//   pcWrite      : one-cycle pulse after a completed write to r15
// ---------------------------------------------------------------------------
module writeback #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] dataIn1,
    input  logic [DW-1:0] dataIn2,
    input  logic [3:0]    addrIn1,
    input  logic [3:0]    addrIn2,
    input  logic [3:0]    flagsIn,
    input  logic [3:0]    typeIn,
    input  logic          triggerIn,
    output logic          readyOut,
    output logic [DW-1:0] dataOutRB,
    output logic [AW-1:0] addrOutRB,
    output logic          triggerOutRB,
    input  logic          readyInRB,
    output logic          pcWrite
);

    typedef enum logic [2:0] {
        IDLE,
        W1,
        W2,
        WC,
        DONE
    } state_t;

    localparam logic [4:0] CPSR_ADDR = 5'd16;
    localparam logic [3:0] PC_INDEX  = 4'd15;

    state_t        state;
    state_t        next_write;

    logic          phase;
    logic          ready_q;
    logic          issued;
    logic          trig_q;
    logic          pc_q;

    logic [DW-1:0] data1_q;
    logic [DW-1:0] data2_q;
    logic [3:0]    addr1_q;
    logic [3:0]    addr2_q;
    logic [3:0]    flags_q;
    logic [2:0]    type_q;

    logic [DW-1:0] dout_q;
    logic [4:0]    aout_q;

    logic [4:0]    issue_addr;
    logic [DW-1:0] issue_data;
    logic          completes_pc;

    // typeIn[3] is reserved and has no effect on the stage
    logic          type_unused;
    assign type_unused = typeIn[3];

    // Picks the first enabled write in the fixed order W1, W2, WC.
    // Callers mask off the writes that are already behind them.
    function automatic state_t pick_write(input logic [2:0] en);
        state_t result;
        if (en[0]) begin
            result = W1;
        end else if (en[1]) begin
            result = W2;
        end else if (en[2]) begin
            result = WC;
        end else begin
            result = DONE;
        end
        return result;
    endfunction

    // Per-write-state view: what to put on the bank port, where to go once
    // the bank acknowledges, and whether this write lands on r15.
    always_comb begin
        issue_addr   = '0;
        issue_data   = '0;
        next_write   = DONE;
        completes_pc = 1'b0;
        case (state)
            W1: begin
                issue_addr   = {1'b0, addr1_q};
                issue_data   = data1_q;
                next_write   = pick_write({type_q[2], type_q[1], 1'b0});
                completes_pc = (addr1_q == PC_INDEX);
            end
            W2: begin
                issue_addr   = {1'b0, addr2_q};
                issue_data   = data2_q;
                next_write   = pick_write({type_q[2], 2'b00});
                completes_pc = (addr2_q == PC_INDEX);
            end
            WC: begin
                issue_addr   = CPSR_ADDR;
                issue_data   = {flags_q, {(DW-4){1'b0}}};
                next_write   = DONE;
            end
            default: begin
            end
        endcase
    end

    // Main sequencer. A write state spends its first cycle issuing the
    // request (address, data and a trigger toggle, all in one edge) and
    // then waits for the bank phase to match. 'issued' separates the two.
    // pcWrite defaults low every cycle so it can only ever be a pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            phase   <= 1'b0;
            ready_q <= 1'b1;
            issued  <= 1'b0;
            trig_q  <= 1'b0;
            pc_q    <= 1'b0;
            dout_q  <= '0;
            aout_q  <= '0;
            data1_q <= '0;
            data2_q <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
            flags_q <= '0;
            type_q  <= '0;
        end else begin
            pc_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (triggerIn != phase) begin
                        data1_q <= dataIn1;
                        data2_q <= dataIn2;
                        addr1_q <= addrIn1;
                        addr2_q <= addrIn2;
                        flags_q <= flagsIn;
                        type_q  <= typeIn[2:0];
                        phase   <= triggerIn;
                        ready_q <= 1'b0;
                        issued  <= 1'b0;
                        state   <= pick_write(typeIn[2:0]);
                    end
                end
                W1, W2, WC: begin
                    if (!issued) begin
                        aout_q <= issue_addr;
                        dout_q <= issue_data;
                        trig_q <= ~trig_q;
                        issued <= 1'b1;
                    end else if (readyInRB == trig_q) begin
                        issued <= 1'b0;
                        pc_q   <= completes_pc;
                        state  <= next_write;
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // readyOut also drops as soon as a new phase appears at the input, so
    // upstream never sees "ready" while an item sits unaccepted. This is
    // what makes an empty item read as two cycles of not-ready.
    assign readyOut     = ready_q && (triggerIn == phase);
    assign dataOutRB    = dout_q;
    assign addrOutRB    = {{(AW-5){1'b0}}, aout_q};
    assign triggerOutRB = trig_q;
    assign pcWrite      = pc_q;

endmodule

// File: tb/tb_writeback.sv
// ---------------------------------------------------------------------------
// tb_writeback
//
// Directed bench for writeback. A table of items with hand-computed bank
// writes, pcWrite counts and readyOut-low durations is driven through the
// stage, followed by hand-written back-to-back and reset-mid-operation
// sequences. A small register-bank model acknowledges requests after a
// per-item delay and logs every request it sees.
// ---------------------------------------------------------------------------
module tb_writeback;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NV = 8;

    logic          clk;
    logic          reset;
    logic [DW-1:0] dataIn1;
    logic [DW-1:0] dataIn2;
    logic [3:0]    addrIn1;
    logic [3:0]    addrIn2;
    logic [3:0]    flagsIn;
    logic [3:0]    typeIn;
    logic          triggerIn;
    logic          readyOut;
    logic [DW-1:0] dataOutRB;
    logic [AW-1:0] addrOutRB;
    logic          triggerOutRB;
    logic          readyInRB;
    logic          pcWrite;

    writeback #(.DW(DW), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .dataIn1      (dataIn1),
        .dataIn2      (dataIn2),
        .addrIn1      (addrIn1),
        .addrIn2      (addrIn2),
        .flagsIn      (flagsIn),
        .typeIn       (typeIn),
        .triggerIn    (triggerIn),
        .readyOut     (readyOut),
        .dataOutRB    (dataOutRB),
        .addrOutRB    (addrOutRB),
        .triggerOutRB (triggerOutRB),
        .readyInRB    (readyInRB),
        .pcWrite      (pcWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]        typ;
        logic [3:0]        a1;
        logic [3:0]        a2;
        logic [3:0]        fl;
        logic [31:0]       d1;
        logic [31:0]       d2;
        int                dly;
        int                nw;
        logic [2:0][4:0]   ea;
        logic [2:0][31:0]  ed;
        int                npc;
        int                nlow;
    } vec_t;

    vec_t vecs [NV];

    int total = 0;
    int bad   = 0;

    // Register-bank model state
    logic          bank_auto  = 1'b1;
    int            bank_delay = 0;
    int            wait_cnt   = 0;
    int            inject_req = 0;
    int            inject_done = 0;
    logic          prev_trig  = 1'b0;
    logic [AW-1:0] rec_addr [64];
    logic [DW-1:0] rec_data [64];
    int            rec_cnt = 0;
    int            pc_cnt  = 0;

    // Bank model: acknowledges a pending request after bank_delay cycles,
    // or toggles its ack on demand when the bench injects one. Every new
    // request phase is logged with its address and data.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            readyInRB = 1'b0;
            wait_cnt  = 0;
        end else if (inject_req != inject_done) begin
            readyInRB   = ~readyInRB;
            inject_done = inject_req;
        end else if (bank_auto && (triggerOutRB != readyInRB)) begin
            if (wait_cnt >= bank_delay) begin
                readyInRB = triggerOutRB;
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end
        if (reset && (triggerOutRB != prev_trig)) begin
            if (rec_cnt < 64) begin
                rec_addr[rec_cnt] = addrOutRB;
                rec_data[rec_cnt] = dataOutRB;
            end
            rec_cnt++;
        end
        prev_trig = triggerOutRB;
        if (pcWrite) pc_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkvec(
        input logic [3:0] typ, input logic [3:0] a1, input logic [31:0] d1,
        input logic [3:0] a2, input logic [31:0] d2, input logic [3:0] fl,
        input int dly, input int nw,
        input logic [4:0] ea0, input logic [31:0] ed0,
        input logic [4:0] ea1, input logic [31:0] ed1,
        input logic [4:0] ea2, input logic [31:0] ed2,
        input int npc, input int nlow);
        vec_t v;
        v.typ = typ; v.a1 = a1; v.d1 = d1; v.a2 = a2; v.d2 = d2; v.fl = fl;
        v.dly = dly; v.nw = nw;
        v.ea[0] = ea0; v.ed[0] = ed0;
        v.ea[1] = ea1; v.ed[1] = ed1;
        v.ea[2] = ea2; v.ed[2] = ed2;
        v.npc = npc; v.nlow = nlow;
        return v;
    endfunction

    // Drives one item, toggles triggerIn and counts the cycles readyOut
    // stays low (bounded, so a stuck DUT still reaches the summary).
    task automatic applyStimulus(input vec_t v, output int low);
        bit finished;
        typeIn     = v.typ;
        addrIn1    = v.a1;
        dataIn1    = v.d1;
        addrIn2    = v.a2;
        dataIn2    = v.d2;
        flagsIn    = v.fl;
        bank_delay = v.dly;
        bank_auto  = 1'b1;
        triggerIn  = ~triggerIn;
        #1;
        low = 0;
        finished = 1'b0;
        if (!readyOut) low++;
        for (int i = 0; i < 100 && !finished; i++) begin
            tick();
            if (!readyOut) low++;
            else finished = 1'b1;
        end
        checkOutput("item finished", {63'd0, finished}, 64'd1);
    endtask

    task automatic runVector(input string tag, input vec_t v);
        int base;
        int pbase;
        int low;
        base  = rec_cnt;
        pbase = pc_cnt;
        applyStimulus(v, low);
        checkOutput($sformatf("%s low cycles", tag), low, v.nlow);
        checkOutput($sformatf("%s write count", tag), rec_cnt - base, v.nw);
        for (int w = 0; w < v.nw && w < 3; w++) begin
            if (base + w < 64) begin
                checkOutput($sformatf("%s w%0d addr", tag, w), rec_addr[base+w], {59'd0, v.ea[w]});
                checkOutput($sformatf("%s w%0d data", tag, w), rec_data[base+w], {32'd0, v.ed[w]});
            end
        end
        checkOutput($sformatf("%s pcWrite pulses", tag), pc_cnt - pbase, v.npc);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int low;
        vec_t v;

        //            typ     a1  d1            a2  d2            fl     dly nw  writes ...                                                         pc low
        vecs[0] = mkvec(4'b0001, 3, 32'hDEADBEEF, 7, 32'h11111111, 4'h0, 2, 1, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0, 5'd0, 32'h0, 0, 6);
        vecs[1] = mkvec(4'b0111, 15, 32'h12345678, 13, 32'h00000100, 4'hA, 0, 3,
                        5'd15, 32'h12345678, 5'd13, 32'h00000100, 5'd16, 32'hA0000000, 1, 8);
        vecs[2] = mkvec(4'b0000, 1, 32'h1, 2, 32'h2, 4'hF, 0, 0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 0, 2);
        vecs[3] = mkvec(4'b1000, 15, 32'h1, 15, 32'h2, 4'hF, 0, 0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 0, 2);
        vecs[4] = mkvec(4'b0011, 15, 32'hAAAA0001, 15, 32'hBBBB0002, 4'h0, 1, 2,
                        5'd15, 32'hAAAA0001, 5'd15, 32'hBBBB0002, 5'd0, 32'h0, 2, 8);
        vecs[5] = mkvec(4'b0110, 9, 32'h99999999, 0, 32'hCAFEF00D, 4'h5, 0, 2,
                        5'd0, 32'hCAFEF00D, 5'd16, 32'h50000000, 5'd0, 32'h0, 0, 6);
        vecs[6] = mkvec(4'b1101, 15, 32'h00000400, 3, 32'h33333333, 4'hF, 0, 2,
                        5'd15, 32'h00000400, 5'd16, 32'hF0000000, 5'd0, 32'h0, 1, 6);
        vecs[7] = mkvec(4'b0011, 4, 32'h00000001, 4, 32'h00000002, 4'h0, 0, 2,
                        5'd4, 32'h00000001, 5'd4, 32'h00000002, 5'd0, 32'h0, 0, 6);

        // Reset with random data inputs; triggerIn held at the reset phase
        reset     = 1'b0;
        triggerIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dataIn1 = $urandom;
            dataIn2 = $urandom;
            addrIn1 = 4'($urandom);
            addrIn2 = 4'($urandom);
            flagsIn = 4'($urandom);
            typeIn  = 4'($urandom);
            tick();
        end
        reset = 1'b1;
        tick();
        checkOutput("reset readyOut", {63'd0, readyOut}, 64'd1);
        checkOutput("reset triggerOutRB", {63'd0, triggerOutRB}, 64'd0);
        checkOutput("reset pcWrite", {63'd0, pcWrite}, 64'd0);
        checkOutput("reset addrOutRB", {32'd0, addrOutRB}, 64'd0);
        checkOutput("reset dataOutRB", {32'd0, dataOutRB}, 64'd0);
        tick();
        tick();
        checkOutput("reset no bank activity", rec_cnt, 0);

        for (int i = 0; i < NV; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
        end

        // Back-to-back: second toggle lands while the first item is busy
        base       = rec_cnt;
        bank_delay = 1;
        bank_auto  = 1'b1;
        typeIn     = 4'b0001;
        addrIn1    = 4'd3;
        dataIn1    = 32'h00000011;
        triggerIn  = ~triggerIn;
        tick();
        tick();
        addrIn1    = 4'd5;
        dataIn1    = 32'h00000022;
        triggerIn  = ~triggerIn;
        #1;
        for (int i = 0; i < 60 && (!readyOut || rec_cnt - base < 2); i++) tick();
        tick();
        checkOutput("b2b readyOut", {63'd0, readyOut}, 64'd1);
        checkOutput("b2b write count", rec_cnt - base, 2);
        checkOutput("b2b w0 addr", rec_addr[base], 64'd3);
        checkOutput("b2b w0 data", rec_data[base], 64'h11);
        checkOutput("b2b w1 addr", rec_addr[base+1], 64'd5);
        checkOutput("b2b w1 data", rec_data[base+1], 64'h22);

        // Reset while W2 waits for its ack
        base      = rec_cnt;
        bank_auto = 1'b0;
        typeIn    = 4'b0011;
        addrIn1   = 4'd1;
        dataIn1   = 32'h0000AAAA;
        addrIn2   = 4'd2;
        dataIn2   = 32'h0000BBBB;
        triggerIn = ~triggerIn;
        for (int i = 0; i < 20 && rec_cnt - base < 1; i++) tick();
        checkOutput("midrst w1 issued", rec_cnt - base, 1);
        inject_req++;
        for (int i = 0; i < 20 && rec_cnt - base < 2; i++) tick();
        checkOutput("midrst w2 issued", rec_cnt - base, 2);
        checkOutput("midrst w2 addr", {32'd0, addrOutRB}, 64'd2);
        tick();
        reset     = 1'b0;
        triggerIn = 1'b0;
        tick();
        checkOutput("midrst readyOut", {63'd0, readyOut}, 64'd1);
        checkOutput("midrst triggerOutRB", {63'd0, triggerOutRB}, 64'd0);
        checkOutput("midrst addrOutRB", {32'd0, addrOutRB}, 64'd0);
        checkOutput("midrst dataOutRB", {32'd0, dataOutRB}, 64'd0);
        checkOutput("midrst pcWrite", {63'd0, pcWrite}, 64'd0);
        reset = 1'b1;
        tick();
        inject_req++;
        tick();
        tick();
        tick();
        checkOutput("late ack no request", rec_cnt - base, 2);
        checkOutput("late ack triggerOutRB", {63'd0, triggerOutRB}, 64'd0);
        checkOutput("late ack readyOut", {63'd0, readyOut}, 64'd1);
        inject_req++;
        tick();
        tick();
        checkOutput("resync readyInRB", {63'd0, readyInRB}, 64'd0);

        v = mkvec(4'b0001, 6, 32'h600DF00D, 0, 32'h0, 4'h0, 0, 1,
                  5'd6, 32'h600DF00D, 5'd0, 32'h0, 5'd0, 32'h0, 0, 4);
        runVector("after reset", v);
        low = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
